cs_to_bin_conv: RTL and testbench
=================================

CS_TO_BIN_CONV -- requirements
Module: cs_to_bin_conv

Interface
REQ-001 Parameter W, default 16: width of each carry-save input vector; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4: bits added per cycle.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  carry-save pair on in_sum/in_carry is valid.
REQ-006 in_ready  output  1  block can accept a pair.
REQ-007 in_sum  input  W  sum vector from the 4:2 compressor row, bit i has weight 2^i.
REQ-008 in_carry  input  W  carry vector from the 4:2 compressor row, bit i has weight 2^(i+1).
REQ-009 out_valid  output  1  out_res holds a completed binary result.
REQ-010 out_ready  input  1  consumer accepts out_res.
REQ-011 out_res  output  W+2  binary value in_sum + 2*in_carry.

Function
REQ-012 Operands: A = zero-extended in_sum, B = {in_carry, 1'b0} zero-extended, both W+DIGIT bits; NDIG = W/DIGIT + 1 digits.
REQ-013 States: IDLE, ADD, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: on edge with in_valid=1, register A and B, clear digit counter and carry register, go to ADD; otherwise stay.
REQ-015 ADD: each edge adds digit cnt of A, B and the carry register, writes the DIGIT-bit sum into result digit cnt, updates carry, increments cnt.
REQ-016 ADD: on the edge processing digit NDIG-1, go to DONE.
REQ-017 Latency: pair accepted at edge E0 -> out_valid high after edge E0+NDIG (W=16: 5 edges).
REQ-018 DONE: out_res and out_valid held stable while out_ready=0; on edge with out_ready=1 go to IDLE.
REQ-019 Bits above W+1 of the internal result SHALL always be 0; out_res = low W+2 bits, exact, no truncation.
REQ-020 in_valid during ADD/DONE SHALL be ignored (no capture, no corruption).
REQ-021 Minimum spacing between accepts is NDIG+2 cycles (no DONE->accept bypass).
REQ-022 Input vectors SHALL NOT need to be held after the accept edge.

Reset
REQ-023 rst=1 forces IDLE immediately: in_ready=1, out_valid=0, out_res=0, counter=0, carry=0.
REQ-024 rst during ADD or DONE discards the in-flight pair; no partial result ever appears on out_valid.
REQ-025 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro CS_CONV_OVF_EN: when defined, adds output out_ovf (1 bit), valid with out_valid, = 1 when out_res >= 2^W, 0 in reset/IDLE/ADD.
REQ-027 Without CS_CONV_OVF_EN, out_ovf port and its logic SHALL NOT exist; all other behaviour identical.

Structure
REQ-028 Package cs_conv_pkg SHALL hold the state enum (IDLE/ADD/DONE) and the default DIGIT constant.
REQ-029 Sub-module cs_digit_add: combinational DIGIT-bit adder (a, b, cin -> sum, cout), instantiated once and reused each ADD cycle.

Verification
REQ-030 W=16: in_sum=0x0001, in_carry=0x0000 -> out_res=0x00001 after 5 edges, out_ovf=0.
REQ-031 W=16: in_sum=0xFFFF, in_carry=0xFFFF -> out_res=0x2FFFD, out_ovf=1.
REQ-032 W=16: in_sum=0x00F0, in_carry=0x0008 -> out_res=0x00100 (carry rippling across digits).
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_res/out_valid stable; in_valid pulses ignored; release -> IDLE next edge.
REQ-034 rst asserted mid-ADD (digit 2) -> out_valid stays 0, in_ready=1 immediately; next pair 0x1234/0x0001 -> 0x01236.
REQ-035 Random s,c (1000 pairs) with random valid/ready gaps -> every out_res equals s+2c, one result per accepted pair, in order.

Source files
------------

// File: rtl/cs_conv_pkg.sv
// ---------------------------------------------------------------------------
// cs_conv_pkg
//   Shared definitions for the carry-save to binary converter.
//   - conv_state_t  : converter control states (IDLE / ADD / DONE)
//   - DEFAULT_DIGIT : default number of bits resolved per ADD cycle
// ---------------------------------------------------------------------------
package cs_conv_pkg;

  // Default digit width; W must be a multiple of this.
  localparam int DEFAULT_DIGIT = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage : cs_conv_pkg

// File: rtl/cs_digit_add.sv
// ---------------------------------------------------------------------------
// cs_digit_add
//   Combinational DIGIT-bit ripple adder used as the per-cycle digit slice
//   of the carry-save to binary converter.
//
//   Parameters:
//     DIGIT : operand width in bits
//   Ports:
//     a, b  : DIGIT-bit operands
//     cin   : carry in
//     sum   : DIGIT-bit sum
//     cout  : carry out of the digit
// ---------------------------------------------------------------------------
module cs_digit_add
  import cs_conv_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  // The adder is one bit wider than the digit so the carry out falls out of
  // the top bit of the addition.
  logic [DIGIT:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    sum   = total[DIGIT-1:0];
    cout  = total[DIGIT];
  end

endmodule : cs_digit_add

// File: rtl/cs_to_bin_conv.sv
// ---------------------------------------------------------------------------
// cs_to_bin_conv
//   Sequential carry-save to binary converter. A sum/carry pair from a 4:2
//   compressor row is captured in IDLE, then resolved DIGIT bits per cycle
//   in ADD using a single cs_digit_add slice, and presented in DONE until the
//   consumer accepts it.
//
//   Parameters:
//     W     : width of in_sum / in_carry (multiple of DIGIT)
//     DIGIT : bits resolved per cycle
//   Ports:
//     clk       : clock, rising edge
//     rst       : asynchronous active-high reset
//     in_valid  : input pair valid
//     in_ready  : converter idle and able to accept a pair
//     in_sum    : sum vector, bit i weight 2^i
//     in_carry  : carry vector, bit i weight 2^(i+1)
//     out_valid : out_res holds a completed result
//     out_ready : consumer accepts out_res
//     out_res   : in_sum + 2*in_carry, W+2 bits
//     out_ovf   : (only with CS_CONV_OVF_EN) result >= 2^W, valid with
//                 out_valid
//
//   Build option: define CS_CONV_OVF_EN to add the out_ovf output.
// ---------------------------------------------------------------------------
module cs_to_bin_conv
  import cs_conv_pkg::*;
#(
  parameter int W     = 16,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef CS_CONV_OVF_EN
  output logic [W+1:0] out_res,
  output logic         out_ovf
`else
  output logic [W+1:0] out_res
`endif
);

  // One extra digit holds the bits shifted out by the carry weighting and
  // the final carry, so the full sum always fits.
  localparam int NDIG = W / DIGIT + 1;
  localparam int OW   = W + DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  conv_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [OW-1:0]   a_q;
  logic [OW-1:0]   b_q;
  logic [OW-1:0]   res_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;

  // The operand range guarantees the result never reaches bit W+2; those
  // bits are kept only to make every digit write uniform.
  logic unused_res_top;
  assign unused_res_top = ^res_q[OW-1:W+2];

  // Select the digit currently being resolved from both operands.
  always_comb begin
    a_dig = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig = b_q[cnt_q*DIGIT +: DIGIT];
  end

  cs_digit_add #(
    .DIGIT (DIGIT)
  ) u_digit_add (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs. DONE always returns to IDLE
  // rather than accepting directly, so back-to-back accepts are spaced by
  // at least one IDLE cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ADD;
        end
      end
      ADD: begin
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operands are captured on accept so the producer may change
  // its inputs immediately; each ADD cycle fills one result digit. Inputs
  // outside IDLE are never looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= OW'(in_sum);
            b_q     <= OW'({in_carry, 1'b0});
            cnt_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        ADD: begin
          res_q[cnt_q*DIGIT +: DIGIT] <= dig_sum;
          carry_q                     <= dig_cout;
          cnt_q                       <= cnt_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_res = res_q[W+1:0];

`ifdef CS_CONV_OVF_EN
  // Anything in the top two result bits means the value needs more than W
  // bits; forced low outside DONE.
  assign out_ovf = (state_q == DONE) && (res_q[W+1:W] != 2'b00);
`endif

endmodule : cs_to_bin_conv

// File: tb/tb_cs_to_bin_conv.sv
// ---------------------------------------------------------------------------
// tb_cs_to_bin_conv
//   Self-checking bench for cs_to_bin_conv (W=16, DIGIT=4). Every accepted
//   pair pushes its expected value onto a scoreboard queue; every output
//   handshake pops and compares. A vector table, latency, stall, reset and
//   random sequences drive the DUT. Define CS_CONV_OVF_EN to also check
//   out_ovf.
// ---------------------------------------------------------------------------
module tb_cs_to_bin_conv;

  localparam int W     = 16;
  localparam int DIGIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] out_res;
`ifdef CS_CONV_OVF_EN
  logic         out_ovf;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [W+1:0] expQ[$];

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W+1:0] res;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  cs_to_bin_conv #(
    .W     (W),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CS_CONV_OVF_EN
    .out_res   (out_res),
    .out_ovf   (out_ovf)
`else
    .out_res   (out_res)
`endif
  );

  // Reference model: plain binary sum of the two weighted vectors.
  function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [W+1:0] actual,
                             input logic [W+1:0] required);
    testCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Drive one pair and hold it until accepted; returns the number of cycles
  // spent waiting for in_ready. Ends 1 ns after the accept edge with the
  // inputs scrambled so the DUT must have captured them.
  task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] c,
                               output int waited);
    logic accepted;
    accepted = 1'b0;
    waited   = 0;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        @(posedge clk);
      end else begin
        waited++;
      end
    end
    checkOutput("accept", {17'd0, accepted}, 18'd1);
    #1;
    in_valid = 1'b0;
    in_sum   = W'($urandom);
    in_carry = W'($urandom);
  endtask

  // Wait (bounded) at negedges until out_valid is seen.
  task automatic waitOutValid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {17'd0, out_valid}, 18'd1);
  endtask

  // Scoreboard monitor, sampling between active edges.
  always @(negedge clk) begin
    logic [W+1:0] e;
    int           pending;
    if (rst) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        pending = expQ.size();
        checkOutput("sb_pending", {17'd0, (pending != 0)}, 18'd1);
        if (pending != 0) begin
          e = expQ.pop_front();
          checkOutput("sb_res", out_res, e);
`ifdef CS_CONV_OVF_EN
          checkOutput("sb_ovf", {17'd0, out_ovf}, {17'd0, (e[W+1:W] != 2'b00)});
`endif
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(in_sum, in_carry));
      end
    end
  end

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  w;
    int  lat;
    bit  randDone;
    logic [W-1:0] rs, rc;

    vecs[0] = '{16'h0001, 16'h0000, 18'h00001};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 18'h2FFFD};
    vecs[2] = '{16'h00F0, 16'h0008, 18'h00100};
    vecs[3] = '{16'h1234, 16'h0001, 18'h01236};
    vecs[4] = '{16'h0000, 16'h0000, 18'h00000};
    vecs[5] = '{16'hFFFF, 16'h0000, 18'h0FFFF};
    vecs[6] = '{16'h0000, 16'hFFFF, 18'h1FFFE};
    vecs[7] = '{16'h8000, 16'h8000, 18'h18000};
    vecs[8] = '{16'hAAAA, 16'h5555, 18'h15554};
    vecs[9] = '{16'h0001, 16'h8000, 18'h10001};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {17'd0, in_ready}, 18'd1);
    checkOutput("rst_out_valid", {17'd0, out_valid}, 18'd0);
    checkOutput("rst_out_res", out_res, 18'd0);
`ifdef CS_CONV_OVF_EN
    checkOutput("rst_ovf", {17'd0, out_ovf}, 18'd0);
`endif
    rst = 1'b0;

    // First accept on the first edge after reset release, then latency.
    applyStimulus(16'h0001, 16'h0000, w);
    checkOutput("first_accept_wait", 18'(w), 18'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
`ifdef CS_CONV_OVF_EN
      if (lat == 1) checkOutput("ovf_in_add", {17'd0, out_ovf}, 18'd0);
`endif
    end while (!out_valid && lat < 20);
    checkOutput("latency", 18'(lat), 18'd5);
    checkOutput("latency_res", out_res, 18'h00001);
    @(posedge clk);
    #1;

    // Table of directed vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].s, vecs[i].c, w);
      waitOutValid($sformatf("vec%0d_valid", i));
      checkOutput($sformatf("vec%0d_res", i), out_res, vecs[i].res);
`ifdef CS_CONV_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), {17'd0, out_ovf},
                  {17'd0, (vecs[i].res >= 18'h10000)});
`endif
      @(posedge clk);
      #1;
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    out_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0008, w);
    waitOutValid("stall_done");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      @(negedge clk);
      checkOutput("stall_valid", {17'd0, out_valid}, 18'd1);
      checkOutput("stall_res", out_res, 18'h00100);
      checkOutput("stall_in_ready", {17'd0, in_ready}, 18'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", {17'd0, in_ready}, 18'd1);
    checkOutput("release_out_valid", {17'd0, out_valid}, 18'd0);

    // Reset while digit 2 is about to be processed.
    applyStimulus(16'h5555, 16'h1111, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", {17'd0, in_ready}, 18'd1);
    checkOutput("midrst_out_valid", {17'd0, out_valid}, 18'd0);
    checkOutput("midrst_out_res", out_res, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_result", {17'd0, out_valid}, 18'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h1234, 16'h0001, w);
    waitOutValid("postrst_valid");
    checkOutput("postrst_res", out_res, 18'h01236);
    @(posedge clk);
    #1;

    // Random pairs with random input gaps and consumer back-pressure.
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          rs = W'($urandom);
          rc = W'($urandom);
          applyStimulus(rs, rc, w);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 40 && (expQ.size() != 0 || out_valid); n++) begin
      @(negedge clk);
    end
    checkOutput("drain_queue", 18'(expQ.size()), 18'd0);
    checkOutput("drain_out_valid", {17'd0, out_valid}, 18'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_cs_to_bin_conv
